// File: rtl/jt10_adpcm_pkg.sv
// Shared definitions for the ADPCM divider: FSM state encoding and counter sizing.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package jt10_adpcm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Width of an iteration counter that must be able to hold dw.
    function automatic int cnt_width(input int dw);
        return $clog2(dw + 1);
    endfunction

endpackage

// File: rtl/jt10_adpcm_sdiv_if.sv
// Operand/result bundle of the sequential divider.
// Latency: n/a (wires only).
// Backpressure: start is ignored while busy; done is a one-cen-period strobe.
// Ports: start/sgn/a/b from the requester, busy/done/d/r/dz/ovf from the divider.
interface jt10_adpcm_sdiv_if #(
    parameter int dw = 16
);
    logic          start;
    logic          sgn;
    logic [dw-1:0] a;
    logic [dw-1:0] b;
    logic          busy;
    logic          done;
    logic [dw-1:0] d;
    logic [dw-1:0] r;
    logic          dz;
    logic          ovf;

    modport master (
        output start, sgn, a, b,
        input  busy, done, d, r, dz, ovf
    );

    modport slave (
        input  start, sgn, a, b,
        output busy, done, d, r, dz, ovf
    );
endinterface

// File: rtl/jt10_adpcm_div_step.sv
// One restoring shift-subtract step: shift in the next dividend bit, subtract if it fits.
// Latency: combinational.
// Backpressure: none.
// Ports: rem_in/div/bit_in in, rem_out/q_bit out.
module jt10_adpcm_div_step #(
    parameter int dw = 16
) (
    input  logic [dw:0]   rem_in,
    input  logic [dw-1:0] div,
    input  logic          bit_in,
    output logic [dw:0]   rem_out,
    output logic          q_bit
);
    logic [dw+1:0] shifted;
    logic [dw+1:0] trial;

    // The extra top bit of trial is the borrow: the shifted value is always
    // below 2^(dw+1) and the divisor below 2^dw, so dw+2 bits cannot wrap.
    assign shifted = {rem_in, bit_in};
    assign trial   = shifted - {2'b00, div};
    assign q_bit   = ~trial[dw+1];
    assign rem_out = q_bit ? trial[dw:0] : shifted[dw:0];
endmodule

// File: rtl/jt10_adpcm_sdiv.sv
// Sequential signed/unsigned divider, one quotient bit per cen edge, dz/ovf flags.
// Latency: dw+1 cen edges from accepted start to done, independent of operands.
// Backpressure: start ignored while busy; accepted again in the cycle done is high.
// Ports: clk, rst_n (sync, active low), cen, bus (slave side of jt10_adpcm_sdiv_if).
// Build option: JT10_DIV_SIGNED_EN enables signed mode (sgn input, ovf flag).
module jt10_adpcm_sdiv
    import jt10_adpcm_pkg::*;
#(
    parameter int dw = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cen,
    jt10_adpcm_sdiv_if.slave   bus
);
    localparam int cw = cnt_width(dw);
    localparam logic [dw-1:0] smin = {1'b1, {(dw-1){1'b0}}};
    localparam logic [dw-1:0] smax = ~smin;

    state_t        st;
    logic [cw-1:0] cnt;
    logic [dw-1:0] dvd;      // dividend magnitude, quotient bits shift in at the LSB
    logic [dw-1:0] dvs;      // divisor magnitude
    logic [dw:0]   rem;
    logic [dw-1:0] a_lat;
    logic          sgn_lat, sa_lat, qs, dz_f, ovf_f;

    logic          sgn_eff, sa, sb, in_dz, in_ovf;
    logic [dw-1:0] a_mag, b_mag;
    logic [dw:0]   rem_nx;
    logic          q_bit;
    logic [dw-1:0] d_fix, r_fix;

`ifdef JT10_DIV_SIGNED_EN
    assign sgn_eff = bus.sgn;
`else
    logic unused_sgn;
    assign unused_sgn = bus.sgn;
    assign sgn_eff    = 1'b0;
`endif

    // Magnitudes: the most negative value negates to itself, which read
    // unsigned is exactly 2^(dw-1), so no extra bit is needed.
    assign sa     = sgn_eff & bus.a[dw-1];
    assign sb     = sgn_eff & bus.b[dw-1];
    assign a_mag  = sa ? -bus.a : bus.a;
    assign b_mag  = sb ? -bus.b : bus.b;
    assign in_dz  = (bus.b == '0);
    assign in_ovf = sgn_eff && (bus.a == smin) && (bus.b == '1);

    jt10_adpcm_div_step #(.dw(dw)) u_step (
        .rem_in  (rem),
        .div     (dvs),
        .bit_in  (dvd[dw-1]),
        .rem_out (rem_nx),
        .q_bit   (q_bit)
    );

    // Sign post-processing; remainder follows the dividend (truncation toward zero).
    always_comb begin
        d_fix = qs ? -dvd : dvd;
        r_fix = sa_lat ? -rem[dw-1:0] : rem[dw-1:0];
        if (dz_f) begin
            r_fix = a_lat;
            d_fix = !sgn_lat ? '1 : (sa_lat ? smin : smax);
        end else if (ovf_f) begin
            d_fix = smax;
            r_fix = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st       <= IDLE;
            cnt      <= '0;
            dvd      <= '0;
            dvs      <= '0;
            rem      <= '0;
            a_lat    <= '0;
            sgn_lat  <= 1'b0;
            sa_lat   <= 1'b0;
            qs       <= 1'b0;
            dz_f     <= 1'b0;
            ovf_f    <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.d    <= '0;
            bus.r    <= '0;
            bus.dz   <= 1'b0;
            bus.ovf  <= 1'b0;
        end else if (cen) begin
            bus.done <= 1'b0;
            case (st)
                IDLE: begin
                    if (bus.start) begin
                        a_lat    <= bus.a;
                        sgn_lat  <= sgn_eff;
                        sa_lat   <= sa;
                        qs       <= sa ^ sb;
                        dz_f     <= in_dz;
                        ovf_f    <= in_ovf;
                        dvd      <= a_mag;
                        dvs      <= b_mag;
                        rem      <= '0;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        st       <= CALC;
                    end
                end
                CALC: begin
                    dvd <= {dvd[dw-2:0], q_bit};
                    rem <= rem_nx;
                    cnt <= cnt + cw'(1);
                    if (cnt == cw'(dw - 1)) st <= FIX;
                end
                FIX: begin
                    bus.d    <= d_fix;
                    bus.r    <= r_fix;
                    bus.dz   <= dz_f;
                    bus.ovf  <= ovf_f;
                    bus.done <= 1'b1;
                    bus.busy <= 1'b0;
                    st       <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_jt10_adpcm_sdiv.sv
// Self-checking bench for jt10_adpcm_sdiv (dw=16) against an arithmetic reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_jt10_adpcm_sdiv;
`ifdef JT10_DIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic cen;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    jt10_adpcm_sdiv_if #(.dw(16)) bus ();

    jt10_adpcm_sdiv #(.dw(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cen   (cen),
        .bus   (bus)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer division (truncates toward zero, remainder takes
    // the dividend's sign) plus the divide-by-zero and overflow rules.
    function automatic void model(input logic [15:0] ia, ib, input logic isgn,
                                  output logic [15:0] md, mr, output logic mdz, movf);
        bit     s;
        longint av, bv;
        s    = SIGNED_EN && isgn;
        av   = s ? longint'($signed(ia)) : longint'(ia);
        bv   = s ? longint'($signed(ib)) : longint'(ib);
        mdz  = 1'b0;
        movf = 1'b0;
        if (bv == 0) begin
            mdz = 1'b1;
            mr  = ia;
            md  = !s ? 16'hFFFF : (av >= 0 ? 16'h7FFF : 16'h8000);
        end else if (s && av == -32768 && bv == -1) begin
            movf = 1'b1;
            md   = 16'h7FFF;
            mr   = 16'h0000;
        end else begin
            md = 16'(av / bv);
            mr = 16'(av % bv);
        end
    endfunction

    // Issue one op with cen=1; report edges to done, busy-high samples and results.
    task automatic run_op(input logic [15:0] ia, ib, input logic isgn,
                          output int lat, output int bcnt,
                          output logic [15:0] od, orr, output logic odz, oovf);
        bus.a = ia; bus.b = ib; bus.sgn = isgn; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        lat  = 0;
        bcnt = bus.busy ? 1 : 0;
        while (!bus.done && lat < 100) begin
            tick();
            lat++;
            if (bus.busy) bcnt++;
        end
        od = bus.d; orr = bus.r; odz = bus.dz; oovf = bus.ovf;
    endtask

    task automatic test_reset;
        n_tests++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_ctl: busy/done=%b want 00", {bus.busy, bus.done});
        end
        n_tests++;
        if ({bus.d, bus.r, bus.dz, bus.ovf} !== 34'd0) begin
            n_fail++;
            $display("FAIL reset_out: d=%h r=%h dz=%b ovf=%b want all 0", bus.d, bus.r, bus.dz, bus.ovf);
        end
    endtask

    task automatic test_unsigned;
        logic [15:0] ta [4] = '{16'd1235, 16'd3235, 16'd32767, 16'd100};
        logic [15:0] tb [4] = '{16'd23, 16'd123, 16'd1, 16'd1000};
        logic [15:0] td [4] = '{16'd53, 16'd26, 16'd32767, 16'd0};
        logic [15:0] tr [4] = '{16'd16, 16'd37, 16'd0, 16'd100};
        logic [15:0] ia, ib, od, orr, md, mr;
        logic odz, oovf, mdz, movf;
        int lat, bcnt;
        for (int i = 0; i < 24; i++) begin
            if (i < 4) begin ia = ta[i]; ib = tb[i]; end
            else begin
                ia = 16'($urandom);
                ib = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(1, 255)) : 16'($urandom);
            end
            run_op(ia, ib, 1'b0, lat, bcnt, od, orr, odz, oovf);
            model(ia, ib, 1'b0, md, mr, mdz, movf);
            n_tests++;
            if (lat != 17 || bcnt != 17) begin
                n_fail++;
                $display("FAIL unsigned_lat[%0d]: latency=%0d busy=%0d want 17/17", i, lat, bcnt);
            end
            n_tests++;
            if ({od, orr, odz, oovf} !== {md, mr, mdz, movf}) begin
                n_fail++;
                $display("FAIL unsigned_res[%0d] %0d/%0d: d=%0d r=%0d dz=%b ovf=%b want d=%0d r=%0d dz=%b ovf=%b",
                         i, ia, ib, od, orr, odz, oovf, md, mr, mdz, movf);
            end
            if (i < 4) begin
                n_tests++;
                if ({od, orr} !== {td[i], tr[i]}) begin
                    n_fail++;
                    $display("FAIL unsigned_dir[%0d]: d=%0d r=%0d want d=%0d r=%0d", i, od, orr, td[i], tr[i]);
                end
            end
        end
    endtask

    task automatic test_signed;
        logic [15:0] ta [3] = '{16'hFFF9, 16'd7, 16'h8000};
        logic [15:0] tb [3] = '{16'd2, 16'hFFFE, 16'hFFFF};
        logic [15:0] ia, ib, od, orr, md, mr;
        logic odz, oovf, mdz, movf;
        int lat, bcnt;
        for (int i = 0; i < 23; i++) begin
            if (i < 3) begin ia = ta[i]; ib = tb[i]; end
            else begin
                ia = 16'($urandom);
                ib = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            end
            run_op(ia, ib, 1'b1, lat, bcnt, od, orr, odz, oovf);
            model(ia, ib, 1'b1, md, mr, mdz, movf);
            n_tests++;
            if (lat != 17 || bcnt != 17 || {od, orr, odz, oovf} !== {md, mr, mdz, movf}) begin
                n_fail++;
                $display("FAIL signed[%0d] %h/%h: lat=%0d busy=%0d d=%h r=%h dz=%b ovf=%b want lat=17 d=%h r=%h dz=%b ovf=%b",
                         i, ia, ib, lat, bcnt, od, orr, odz, oovf, md, mr, mdz, movf);
            end
        end
    endtask

    task automatic test_div_zero;
        logic [15:0] ta [3] = '{16'd500, 16'hFFFB, 16'd0};
        logic        ts [3] = '{1'b0, 1'b1, 1'b1};
        logic [15:0] od, orr, md, mr;
        logic odz, oovf, mdz, movf;
        int lat, bcnt;
        for (int i = 0; i < 3; i++) begin
            run_op(ta[i], 16'd0, ts[i], lat, bcnt, od, orr, odz, oovf);
            model(ta[i], 16'd0, ts[i], md, mr, mdz, movf);
            n_tests++;
            if (lat != 17 || {od, orr, odz, oovf} !== {md, mr, mdz, movf}) begin
                n_fail++;
                $display("FAIL div_zero[%0d]: lat=%0d d=%h r=%h dz=%b ovf=%b want lat=17 d=%h r=%h dz=%b ovf=%b",
                         i, lat, od, orr, odz, oovf, md, mr, mdz, movf);
            end
        end
    endtask

    task automatic test_ignore_start;
        int n;
        bus.a = 16'd1235; bus.b = 16'd23; bus.sgn = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n = 0;
        repeat (5) begin tick(); n++; end
        bus.a = 16'd9; bus.b = 16'd3; bus.start = 1'b1;
        tick(); n++;
        bus.start = 1'b0;
        while (!bus.done && n < 100) begin tick(); n++; end
        n_tests++;
        if (n != 17 || bus.d !== 16'd53 || bus.r !== 16'd16) begin
            n_fail++;
            $display("FAIL ignore_start: lat=%0d d=%0d r=%0d want lat=17 d=53 r=16", n, bus.d, bus.r);
        end
        tick();
        n_tests++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_idle: busy=%b want 0", bus.busy);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        bus.a = 16'd3235; bus.b = 16'd123; bus.sgn = 1'b0; bus.start = 1'b1;
        tick();
        bus.a = 16'd28000; bus.b = 16'd14000;
        n = 0;
        while (!bus.done && n < 100) begin tick(); n++; end
        n_tests++;
        if (n != 17 || bus.d !== 16'd26 || bus.r !== 16'd37) begin
            n_fail++;
            $display("FAIL b2b_first: lat=%0d d=%0d r=%0d want lat=17 d=26 r=37", n, bus.d, bus.r);
        end
        tick();
        bus.start = 1'b0;
        n_tests++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_bubble: busy=%b done=%b want 1/0", bus.busy, bus.done);
        end
        n = 0;
        while (!bus.done && n < 100) begin tick(); n++; end
        n_tests++;
        if (n != 17 || bus.d !== 16'd2 || bus.r !== 16'd0) begin
            n_fail++;
            $display("FAIL b2b_second: lat=%0d d=%0d r=%0d want lat=17 d=2 r=0", n, bus.d, bus.r);
        end
    endtask

    task automatic test_cen;
        int n;
        bus.a = 16'd28000; bus.b = 16'd14000; bus.sgn = 1'b0; bus.start = 1'b1; cen = 1'b1;
        tick();
        bus.start = 1'b0;
        n = 0;
        while (!bus.done && n < 300) begin
            cen = ((n + 1) % 3 == 0);
            tick();
            n++;
        end
        n_tests++;
        if (n != 51 || bus.d !== 16'd2 || bus.r !== 16'd0) begin
            n_fail++;
            $display("FAIL cen_lat: clk=%0d d=%0d r=%0d want clk=51 d=2 r=0", n, bus.d, bus.r);
        end
        cen = 1'b0;
        bus.start = 1'b1; bus.a = 16'd7; bus.b = 16'd7;
        tick(); tick();
        n_tests++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.d !== 16'd2) begin
            n_fail++;
            $display("FAIL cen_freeze: done=%b busy=%b d=%0d want 1/0/2", bus.done, bus.busy, bus.d);
        end
        bus.start = 1'b0;
        cen = 1'b1;
        tick();
        n_tests++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL cen_clear: done=%b busy=%b want 0/0", bus.done, bus.busy);
        end
    endtask

    task automatic test_reset_mid;
        logic [15:0] od, orr;
        logic odz, oovf;
        int lat, bcnt;
        bus.a = 16'd1235; bus.b = 16'd23; bus.sgn = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (8) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_tests++;
        if ({bus.busy, bus.done, bus.d, bus.r, bus.dz, bus.ovf} !== 36'd0) begin
            n_fail++;
            $display("FAIL reset_mid: busy=%b done=%b d=%h r=%h dz=%b ovf=%b want all 0",
                     bus.busy, bus.done, bus.d, bus.r, bus.dz, bus.ovf);
        end
        run_op(16'd3235, 16'd123, 1'b0, lat, bcnt, od, orr, odz, oovf);
        n_tests++;
        if (lat != 17 || od !== 16'd26 || orr !== 16'd37 || odz !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_after: lat=%0d d=%0d r=%0d dz=%b want 17/26/37/0", lat, od, orr, odz);
        end
    endtask

    initial begin
        rst_n = 1'b0; cen = 1'b1;
        bus.start = 1'b0; bus.sgn = 1'b0; bus.a = '0; bus.b = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_ignore_start();
        test_back_to_back();
        test_cen();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
